// File: rtl/life_pattern_loader.sv
// life_pattern_loader
// Upstream feeder for the 8x8 life array. Collects an 8-row board image from a
// valid/ready byte stream, writes it to the array as four 16-bit tile words,
// and generates generation steps. Steps come periodically while run is high,
// or once on a single_step request while run is low. Stepping is held off
// whenever a load is partly received or being written, so step and write_enb
// never coincide.
//
// Ports
//   clk, reset                      clock; synchronous active-low reset
//   byte_in, byte_valid, byte_ready row stream, row 0 (north) first, bit j = column j
//   run                             enables periodic stepping
//   single_step                     one-cycle request for one step while run is low
//   vali, vali_selector, write_enb  tile write port (sel 0=NW 1=SW 2=NE 3=SE)
//   step                            one-cycle generation strobe
//   load_done                       pulse in the cycle after the fourth tile write
//   busy                            load partly received or being written
//
// state     | meaning
// S_COLLECT | accepting rows into the buffer (byte_ready high)
// S_WRITE   | presenting tile sel_q to the array, one tile per cycle

module life_pattern_loader #(
   parameter int unsigned STEP_PERIOD = 25_000_000,
   parameter int unsigned CNT_W       = 25
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  byte_in,
   input  logic        byte_valid,
   output logic        byte_ready,
   input  logic        run,
   input  logic        single_step,
   output logic [15:0] vali,
   output logic [1:0]  vali_selector,
   output logic        write_enb,
   output logic        step,
   output logic        load_done,
   output logic        busy
);

   typedef enum logic {
      S_COLLECT = 1'b0,
      S_WRITE   = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_PERIOD - 1);

   state_t           state_q;
   logic [2:0]       row_cnt_q;
   logic [63:0]      rows_q;       // row i lives at bits [8i+7:8i]
   logic [63:0]      board_acc;    // board including the byte being accepted now
   logic [CNT_W-1:0] cnt_q;
   logic             pend_q;
   logic [15:0]      vali_q;
   logic [1:0]       sel_q;
   logic [1:0]       sel_d;
   logic             we_q;
   logic             step_q;
   logic             done_q;
   logic             accept;

   // Tile t covers rows 4*t[0].. and columns 4*t[1]..; word bit 4c+r holds
   // board[R+r][C+c], the column-major order the array's neighbour wiring expects.
   function automatic logic [15:0] pack_tile(input logic [63:0] b, input logic [1:0] t);
      logic [15:0] w;
      logic [5:0]  bidx;
      logic [3:0]  widx;
      w = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            bidx    = 6'(8 * ((t[0] ? 4 : 0) + r) + (t[1] ? 4 : 0) + c);
            widx    = 4'(4 * c + r);
            w[widx] = b[bidx];
         end
      end
      return w;
   endfunction

   assign byte_ready    = (state_q == S_COLLECT);
   assign busy          = (state_q == S_WRITE) || (row_cnt_q != 3'd0);
   assign accept        = byte_valid && byte_ready;
   assign sel_d         = sel_q + 2'd1;
   assign vali          = vali_q;
   assign vali_selector = sel_q;
   assign write_enb     = we_q;
   assign step          = step_q;
   assign load_done     = done_q;

   always_comb begin
      board_acc = rows_q;
      board_acc[{row_cnt_q, 3'b000} +: 8] = byte_in;
   end

   // Buffer contents are don't-care after reset; only row_cnt_q gates their use.
   always_ff @(posedge clk) begin
      if (accept) begin
         rows_q[{row_cnt_q, 3'b000} +: 8] <= byte_in;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= S_COLLECT;
         row_cnt_q <= 3'd0;
         vali_q    <= 16'd0;
         sel_q     <= 2'd0;
         we_q      <= 1'b0;
         step_q    <= 1'b0;
         done_q    <= 1'b0;
         cnt_q     <= '0;
         pend_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         step_q <= 1'b0;

         case (state_q)
            S_COLLECT: begin
               if (accept) begin
                  row_cnt_q <= row_cnt_q + 3'd1;
                  if (row_cnt_q == 3'd7) begin
                     state_q <= S_WRITE;
                     sel_q   <= 2'd0;
                     vali_q  <= pack_tile(board_acc, 2'd0);
                     we_q    <= 1'b1;
                  end
               end
            end
            S_WRITE: begin
               if (sel_q == 2'd3) begin
                  state_q <= S_COLLECT;
                  we_q    <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  sel_q  <= sel_d;
                  vali_q <= pack_tile(rows_q, sel_d);
               end
            end
            default: begin
               state_q <= S_COLLECT;
               we_q    <= 1'b0;
            end
         endcase

         // busy covers the cycle a write is launched (row_cnt_q == 7), so a
         // step can never be registered alongside write_enb.
         if (!run) begin
            cnt_q <= '0;
            if (pend_q && !busy) begin
               step_q <= 1'b1;
               pend_q <= 1'b0;
            end else if (single_step) begin
               pend_q <= 1'b1;
            end
         end else begin
            pend_q <= 1'b0;
            if (!busy) begin
               if (cnt_q == CNT_LAST) begin
                  cnt_q  <= '0;
                  step_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
         end
      end
   end

endmodule
